// File: rtl/frame_hop_buffer.sv
// frame_hop_buffer: collects a sample stream into overlapping frames.
// A circular buffer of FRAME_SIZE words holds the most recent samples.
// After the first full frame only HOP_SIZE new samples are gathered
// before the next frame is replayed from 'base', so consecutive frames
// share FRAME_SIZE-HOP_SIZE samples. Optionally the first frame is
// left-padded with zeros written during a CLEAR phase.
//
// Handshake semantics (both ports): a transfer happens on a rising clk
// edge where valid and ready are both high. in_ready_o and out_valid_o
// depend only on registered state, never on the partner's signal in the
// same cycle. Once out_valid_o is high it stays high with out_data_o
// unchanged until out_ready_i accepts the word.
module frame_hop_buffer #(
  parameter int WIDTH      = 16,
  parameter int FRAME_SIZE = 400,
  parameter int HOP_SIZE   = 160,
  parameter bit PAD_FIRST  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_first_o,
  output logic             out_last_o,
  output logic [15:0]      frame_count_o,
  output logic             busy_o
);

  // Address width for the circular buffer and width of the 'need' counter,
  // which has to hold the value FRAME_SIZE itself.
  localparam int AW = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam int NW = $clog2(FRAME_SIZE + 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_FILL  = 2'd1,
    S_EMIT  = 2'd2
  } state_e;

  // Padding only makes sense when frames overlap; with HOP==FRAME there is
  // nothing to pad and the block starts directly in FILL.
  localparam bit     DO_PAD     = PAD_FIRST && (HOP_SIZE < FRAME_SIZE);
  localparam state_e INIT_STATE = DO_PAD ? S_CLEAR : S_FILL;

  localparam logic [AW-1:0] LAST_IDX   = AW'(FRAME_SIZE - 1);
  localparam logic [AW-1:0] CLEAR_LAST = AW'(FRAME_SIZE - HOP_SIZE - 1);
  localparam logic [AW-1:0] ONE_A      = AW'(1);
  localparam logic [AW:0]   F_EXT      = (AW+1)'(FRAME_SIZE);
  localparam logic [AW:0]   H_EXT      = (AW+1)'(HOP_SIZE);
  localparam logic [NW-1:0] NEED_FULL  = NW'(FRAME_SIZE);
  localparam logic [NW-1:0] NEED_HOP   = NW'(HOP_SIZE);
  localparam logic [NW-1:0] ONE_N      = NW'(1);

  // FSM and datapath registers
  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   base_q, base_d;
  logic [AW-1:0]   rd_idx_q, rd_idx_d;
  logic [NW-1:0]   need_q, need_d;
  logic [15:0]     frame_count_q, frame_count_d;

  // Sample storage; contents are deliberately not reset
  logic [WIDTH-1:0] mem_q [FRAME_SIZE];
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;

  // Read address and next base, each wrapped by one conditional subtract
  logic [AW:0]      rd_sum;
  logic [AW-1:0]    rd_addr;
  logic [AW:0]      base_sum;
  logic [AW-1:0]    base_next;

  // Pointer increment that wraps at FRAME_SIZE-1 without a modulo
  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + ONE_A;
  endfunction

  // Wrapped address arithmetic for the frame replay and the hop advance
  always_comb begin
    rd_sum    = {1'b0, base_q} + {1'b0, rd_idx_q};
    rd_addr   = (rd_sum >= F_EXT) ? AW'(rd_sum - F_EXT) : rd_sum[AW-1:0];
    base_sum  = {1'b0, base_q} + H_EXT;
    base_next = (base_sum >= F_EXT) ? AW'(base_sum - F_EXT) : base_sum[AW-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath-update logic; flush overrides every action
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    base_d        = base_q;
    rd_idx_d      = rd_idx_q;
    need_d        = need_q;
    frame_count_d = frame_count_q;
    wr_en         = 1'b0;
    wr_data       = '0;
    if (flush_i) begin
      state_d       = INIT_STATE;
      wr_ptr_d      = '0;
      base_d        = '0;
      rd_idx_d      = '0;
      need_d        = NEED_FULL;
      frame_count_d = '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          // wr_ptr doubles as the zero-fill counter: it starts at 0 and the
          // last zero lands at FRAME_SIZE-HOP_SIZE-1.
          wr_en    = 1'b1;
          wr_data  = '0;
          wr_ptr_d = wrap_inc(wr_ptr_q);
          if (wr_ptr_q == CLEAR_LAST) begin
            state_d = S_FILL;
            need_d  = NEED_HOP;
          end
        end
        S_FILL: begin
          if (in_valid_i) begin
            wr_en    = 1'b1;
            wr_data  = in_data_i;
            wr_ptr_d = wrap_inc(wr_ptr_q);
            need_d   = need_q - ONE_N;
            if (need_q == ONE_N) begin
              state_d  = S_EMIT;
              rd_idx_d = '0;
            end
          end
        end
        S_EMIT: begin
          if (out_ready_i) begin
            if (rd_idx_q == LAST_IDX) begin
              // Frame done: advance the window by one hop, wrapped
              base_d        = base_next;
              need_d        = NEED_HOP;
              frame_count_d = frame_count_q + 16'd1;
              rd_idx_d      = '0;
              state_d       = S_FILL;
            end else begin
              rd_idx_d = rd_idx_q + ONE_A;
            end
          end
        end
        default: begin
          state_d = INIT_STATE;
        end
      endcase
    end
  end

  // Datapath registers: pointers, remaining-sample counter, frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      base_q        <= '0;
      rd_idx_q      <= '0;
      need_q        <= NEED_FULL;
      frame_count_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      base_q        <= base_d;
      rd_idx_q      <= rd_idx_d;
      need_q        <= need_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Single write port into the circular buffer
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    in_ready_o    = (state_q == S_FILL);
    out_valid_o   = (state_q == S_EMIT);
    out_first_o   = (state_q == S_EMIT) && (rd_idx_q == '0);
    out_last_o    = (state_q == S_EMIT) && (rd_idx_q == LAST_IDX);
    busy_o        = (state_q == S_CLEAR) || (state_q == S_EMIT);
    frame_count_o = frame_count_q;
    out_data_o    = mem_q[rd_addr];
  end

endmodule

// File: tb/tb_frame_hop_buffer.sv
// Bench for frame_hop_buffer: four instances cover the unpadded, padded,
// wrapping and non-overlapping configurations. A history queue of every
// sample fed since the last restart is the reference: frame k is simply
// history[k*HOP .. k*HOP+FRAME-1], with leading zeros when padded.
module tb_frame_hop_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  flush, in_valid, out_ready;
  logic [15:0] in_data [4];
  logic [3:0]  in_ready, out_valid, out_first, out_last, busy;
  logic [15:0] out_data [4];
  logic [15:0] frame_count [4];

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc_cnt  = 0;
  int push_to  = 0;

  logic [15:0] model_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int obs_first_bad, obs_last_bad, obs_unstable, obs_rdy_bad;

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  frame_hop_buffer #(.WIDTH(16), .FRAME_SIZE(8), .HOP_SIZE(3), .PAD_FIRST(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush[0]), .in_valid_i(in_valid[0]),
    .in_data_i(in_data[0]), .in_ready_o(in_ready[0]), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready[0]), .out_data_o(out_data[0]), .out_first_o(out_first[0]),
    .out_last_o(out_last[0]), .frame_count_o(frame_count[0]), .busy_o(busy[0]));

  frame_hop_buffer #(.WIDTH(16), .FRAME_SIZE(8), .HOP_SIZE(3), .PAD_FIRST(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush[1]), .in_valid_i(in_valid[1]),
    .in_data_i(in_data[1]), .in_ready_o(in_ready[1]), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready[1]), .out_data_o(out_data[1]), .out_first_o(out_first[1]),
    .out_last_o(out_last[1]), .frame_count_o(frame_count[1]), .busy_o(busy[1]));

  frame_hop_buffer #(.WIDTH(16), .FRAME_SIZE(5), .HOP_SIZE(2), .PAD_FIRST(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush[2]), .in_valid_i(in_valid[2]),
    .in_data_i(in_data[2]), .in_ready_o(in_ready[2]), .out_valid_o(out_valid[2]),
    .out_ready_i(out_ready[2]), .out_data_o(out_data[2]), .out_first_o(out_first[2]),
    .out_last_o(out_last[2]), .frame_count_o(frame_count[2]), .busy_o(busy[2]));

  frame_hop_buffer #(.WIDTH(16), .FRAME_SIZE(4), .HOP_SIZE(4), .PAD_FIRST(1'b0)) u3 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush[3]), .in_valid_i(in_valid[3]),
    .in_data_i(in_data[3]), .in_ready_o(in_ready[3]), .out_valid_o(out_valid[3]),
    .out_ready_i(out_ready[3]), .out_data_o(out_data[3]), .out_first_o(out_first[3]),
    .out_last_o(out_last[3]), .frame_count_o(frame_count[3]), .busy_o(busy[3]));

  // ---------------- driver tasks (entered and left at a negedge) ----------
  task automatic push_sample(input int d, input logic [15:0] v);
    int  n  = 0;
    bit  ok = 1'b0;
    in_valid[d] = 1'b1;
    in_data[d]  = v;
    while (!ok && n < 200) begin
      if (in_ready[d]) ok = 1'b1;
      @(negedge clk);
      n++;
    end
    in_valid[d] = 1'b0;
    if (!ok) push_to++;
  endtask

  task automatic pop_samples(input int d, input int n, input int fsz, input bit stall);
    int          cyc  = 0;
    bit          held = 1'b0;
    logic [15:0] held_data = '0;
    got_q.delete();
    obs_first_bad = 0; obs_last_bad = 0; obs_unstable = 0; obs_rdy_bad = 0;
    while (got_q.size() < n && cyc < 4000) begin
      out_ready[d] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid[d]) begin
        if (held && out_data[d] !== held_data) obs_unstable++;
        if (out_first[d] !== (got_q.size() == 0)) obs_first_bad++;
        if (out_last[d] !== (got_q.size() == fsz - 1)) obs_last_bad++;
        if (in_ready[d] !== 1'b0) obs_rdy_bad++;
        if (out_ready[d]) begin
          got_q.push_back(out_data[d]);
          held = 1'b0;
        end else begin
          held      = 1'b1;
          held_data = out_data[d];
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready[d] = 1'b0;
  endtask

  task automatic flush_dut(input int d);
    flush[d] = 1'b1;
    @(negedge clk);
    flush[d] = 1'b0;
  endtask

  // ---------------- reference model -----------------
  function automatic void build_exp(input int k, input int fsz, input int hop);
    exp_q.delete();
    for (int i = 0; i < fsz; i++) exp_q.push_back(model_q[k * hop + i]);
  endfunction

  function automatic int frame_diff();
    int m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return m;
    return -1;
  endfunction

  function automatic logic [15:0] got_at(input int i);
    return (i >= 0 && i < got_q.size()) ? got_q[i] : 16'hxxxx;
  endfunction

  function automatic logic [15:0] exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 16'hxxxx;
  endfunction

  // ---------------- tests -----------------
  task automatic test_reset();
    chk_cnt++; if (out_valid !== 4'b0000) $display("FAIL reset_out_valid: got %b expected 0000", out_valid); else pass_cnt++;
    chk_cnt++; if (out_first !== 4'b0000) $display("FAIL reset_out_first: got %b expected 0000", out_first); else pass_cnt++;
    chk_cnt++; if (out_last !== 4'b0000) $display("FAIL reset_out_last: got %b expected 0000", out_last); else pass_cnt++;
    chk_cnt++; if (busy !== 4'b0010) $display("FAIL reset_busy: got %b expected 0010", busy); else pass_cnt++;
    chk_cnt++; if (in_ready !== 4'b1101) $display("FAIL reset_in_ready: got %b expected 1101", in_ready); else pass_cnt++;
    for (int d = 0; d < 4; d++) begin
      chk_cnt++;
      if (frame_count[d] !== 16'd0) $display("FAIL reset_count%0d: got %0d expected 0", d, frame_count[d]);
      else pass_cnt++;
    end
  endtask

  task automatic test_basic();
    int df;
    push_to = 0;
    model_q.delete();
    for (int v = 1; v <= 11; v++) model_q.push_back(16'(v));
    for (int k = 0; k < 2; k++) begin
      if (k == 0) for (int i = 0; i < 8; i++) push_sample(0, model_q[i]);
      else        for (int i = 8; i < 11; i++) push_sample(0, model_q[i]);
      pop_samples(0, 8, 8, 1'b0);
      build_exp(k, 8, 3);
      df = frame_diff();
      chk_cnt++;
      if (df != -1) $display("FAIL basic_frame%0d: idx %0d got %0h expected %0h", k, df, got_at(df), exp_at(df));
      else pass_cnt++;
      chk_cnt++;
      if (obs_first_bad + obs_last_bad != 0) $display("FAIL basic_flags%0d: got %0d bad first/last expected 0", k, obs_first_bad + obs_last_bad);
      else pass_cnt++;
      chk_cnt++;
      if (frame_count[0] !== 16'(k + 1)) $display("FAIL basic_count%0d: got %0d expected %0d", k, frame_count[0], k + 1);
      else pass_cnt++;
    end
    chk_cnt++; if (push_to != 0) $display("FAIL basic_push_timeout: got %0d expected 0", push_to); else pass_cnt++;
  endtask

  task automatic test_pad();
    int z = 0;
    int df;
    push_to = 0;
    flush_dut(1);
    chk_cnt++; if (busy[1] !== 1'b1) $display("FAIL pad_busy: got %b expected 1", busy[1]); else pass_cnt++;
    while (in_ready[1] === 1'b0 && z < 20) begin
      z++;
      @(negedge clk);
    end
    chk_cnt++; if (z != 5) $display("FAIL pad_clear_cycles: got %0d expected 5", z); else pass_cnt++;
    model_q.delete();
    for (int i = 0; i < 5; i++) model_q.push_back(16'd0);
    for (int v = 1; v <= 6; v++) model_q.push_back(16'(v));
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) push_sample(1, model_q[5 + 3 * k + i]);
      pop_samples(1, 8, 8, 1'b0);
      build_exp(k, 8, 3);
      df = frame_diff();
      chk_cnt++;
      if (df != -1) $display("FAIL pad_frame%0d: idx %0d got %0h expected %0h", k, df, got_at(df), exp_at(df));
      else pass_cnt++;
    end
    chk_cnt++; if (push_to != 0) $display("FAIL pad_push_timeout: got %0d expected 0", push_to); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int df;
    push_to = 0;
    flush_dut(0);
    model_q.delete();
    for (int i = 0; i < 8 + 3 * 4; i++) model_q.push_back(16'($urandom));
    for (int k = 0; k < 5; k++) begin
      for (int i = (k == 0 ? 0 : 8 + 3 * (k - 1)); i < 8 + 3 * k; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        push_sample(0, model_q[i]);
      end
      pop_samples(0, 8, 8, 1'b1);
      build_exp(k, 8, 3);
      df = frame_diff();
      chk_cnt++;
      if (df != -1) $display("FAIL bp_frame%0d: idx %0d got %0h expected %0h", k, df, got_at(df), exp_at(df));
      else pass_cnt++;
      chk_cnt++;
      if (obs_unstable + obs_rdy_bad + obs_first_bad + obs_last_bad != 0)
        $display("FAIL bp_stall%0d: unstable %0d in_ready_in_emit %0d flags %0d expected all 0",
                 k, obs_unstable, obs_rdy_bad, obs_first_bad + obs_last_bad);
      else pass_cnt++;
    end
    chk_cnt++; if (frame_count[0] !== 16'd5) $display("FAIL bp_count: got %0d expected 5", frame_count[0]); else pass_cnt++;
    chk_cnt++; if (push_to != 0) $display("FAIL bp_push_timeout: got %0d expected 0", push_to); else pass_cnt++;
  endtask

  task automatic test_flush_mid();
    int df;
    push_to = 0;
    flush_dut(0);
    model_q.delete();
    for (int v = 1; v <= 11; v++) model_q.push_back(16'(v));
    for (int i = 0; i < 8; i++) push_sample(0, model_q[i]);
    pop_samples(0, 8, 8, 1'b0);
    for (int i = 8; i < 11; i++) push_sample(0, model_q[i]);
    pop_samples(0, 4, 8, 1'b0);
    build_exp(1, 8, 3);
    while (exp_q.size() > 4) void'(exp_q.pop_back());
    df = frame_diff();
    chk_cnt++;
    if (df != -1) $display("FAIL flush_partial: idx %0d got %0h expected %0h", df, got_at(df), exp_at(df));
    else pass_cnt++;
    flush_dut(0);
    chk_cnt++; if (out_valid[0] !== 1'b0) $display("FAIL flush_out_valid: got %b expected 0", out_valid[0]); else pass_cnt++;
    chk_cnt++; if (frame_count[0] !== 16'd0) $display("FAIL flush_count: got %0d expected 0", frame_count[0]); else pass_cnt++;
    model_q.delete();
    for (int v = 100; v <= 107; v++) model_q.push_back(16'(v));
    for (int i = 0; i < 8; i++) push_sample(0, model_q[i]);
    pop_samples(0, 8, 8, 1'b0);
    build_exp(0, 8, 3);
    df = frame_diff();
    chk_cnt++;
    if (df != -1) $display("FAIL flush_fresh: idx %0d got %0h expected %0h", df, got_at(df), exp_at(df));
    else pass_cnt++;
    chk_cnt++; if (frame_count[0] !== 16'd1) $display("FAIL flush_fresh_count: got %0d expected 1", frame_count[0]); else pass_cnt++;
    chk_cnt++; if (push_to != 0) $display("FAIL flush_push_timeout: got %0d expected 0", push_to); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int t0, t1, t2, df;
    push_to = 0;
    flush_dut(0);
    model_q.delete();
    for (int i = 0; i < 11; i++) model_q.push_back(16'($urandom));
    t0 = cyc_cnt;
    for (int i = 0; i < 8; i++) push_sample(0, model_q[i]);
    pop_samples(0, 8, 8, 1'b0);
    t1 = cyc_cnt;
    for (int i = 8; i < 11; i++) push_sample(0, model_q[i]);
    pop_samples(0, 8, 8, 1'b0);
    t2 = cyc_cnt;
    build_exp(1, 8, 3);
    df = frame_diff();
    chk_cnt++;
    if (df != -1) $display("FAIL b2b_frame: idx %0d got %0h expected %0h", df, got_at(df), exp_at(df));
    else pass_cnt++;
    chk_cnt++; if (t1 - t0 != 16) $display("FAIL b2b_first_period: got %0d expected 16", t1 - t0); else pass_cnt++;
    chk_cnt++; if (t2 - t1 != 11) $display("FAIL b2b_next_period: got %0d expected 11", t2 - t1); else pass_cnt++;
  endtask

  task automatic test_wrap();
    int df;
    int bad = 0;
    push_to = 0;
    model_q.delete();
    for (int v = 1; v <= 5 + 2 * 19; v++) model_q.push_back(16'(v));
    for (int k = 0; k < 20; k++) begin
      for (int i = (k == 0 ? 0 : 5 + 2 * (k - 1)); i < 5 + 2 * k; i++) push_sample(2, model_q[i]);
      pop_samples(2, 5, 5, 1'b1);
      build_exp(k, 5, 2);
      df = frame_diff();
      chk_cnt++;
      if (df != -1) $display("FAIL wrap_frame%0d: idx %0d got %0h expected %0h", k, df, got_at(df), exp_at(df));
      else pass_cnt++;
      if (obs_first_bad + obs_last_bad + obs_unstable != 0) bad++;
    end
    chk_cnt++; if (bad != 0) $display("FAIL wrap_flags: got %0d bad frames expected 0", bad); else pass_cnt++;
    chk_cnt++; if (frame_count[2] !== 16'd20) $display("FAIL wrap_count: got %0d expected 20", frame_count[2]); else pass_cnt++;
    chk_cnt++; if (push_to != 0) $display("FAIL wrap_push_timeout: got %0d expected 0", push_to); else pass_cnt++;
  endtask

  task automatic test_disjoint();
    int df;
    push_to = 0;
    model_q.delete();
    for (int i = 0; i < 12; i++) model_q.push_back(16'($urandom));
    for (int k = 0; k < 3; k++) begin
      for (int i = 4 * k; i < 4 * k + 4; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        push_sample(3, model_q[i]);
      end
      pop_samples(3, 4, 4, 1'b1);
      build_exp(k, 4, 4);
      df = frame_diff();
      chk_cnt++;
      if (df != -1) $display("FAIL disjoint_frame%0d: idx %0d got %0h expected %0h", k, df, got_at(df), exp_at(df));
      else pass_cnt++;
    end
    chk_cnt++; if (frame_count[3] !== 16'd3) $display("FAIL disjoint_count: got %0d expected 3", frame_count[3]); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int df;
    push_to = 0;
    flush_dut(0);
    for (int i = 0; i < 5; i++) push_sample(0, 16'($urandom));
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if (in_ready[0] !== 1'b1) $display("FAIL areset_in_ready: got %b expected 1", in_ready[0]); else pass_cnt++;
    chk_cnt++; if (out_valid !== 4'b0000) $display("FAIL areset_out_valid: got %b expected 0000", out_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 4'b0010) $display("FAIL areset_busy: got %b expected 0010", busy); else pass_cnt++;
    chk_cnt++; if (frame_count[2] !== 16'd0) $display("FAIL areset_count2: got %0d expected 0", frame_count[2]); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    model_q.delete();
    for (int i = 0; i < 8; i++) model_q.push_back(16'($urandom));
    for (int i = 0; i < 8; i++) push_sample(0, model_q[i]);
    pop_samples(0, 8, 8, 1'b0);
    build_exp(0, 8, 3);
    df = frame_diff();
    chk_cnt++;
    if (df != -1) $display("FAIL areset_frame: idx %0d got %0h expected %0h", df, got_at(df), exp_at(df));
    else pass_cnt++;
    chk_cnt++; if (frame_count[0] !== 16'd1) $display("FAIL areset_count0: got %0d expected 1", frame_count[0]); else pass_cnt++;
    chk_cnt++; if (push_to != 0) $display("FAIL areset_push_timeout: got %0d expected 0", push_to); else pass_cnt++;
  endtask

  // ---------------- sequence + final report -----------------
  initial begin
    rst_n     = 1'b1;
    flush     = '0;
    in_valid  = '0;
    out_ready = '0;
    for (int d = 0; d < 4; d++) in_data[d] = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_pad();
    test_backpressure();
    test_flush_mid();
    test_back_to_back();
    test_wrap();
    test_disjoint();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
